wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port (we/a3/din) among N_REQ writeback sources:
//  0 = ALU pipe, 1 = load unit, 2 = mul/div.
//  Fixed priority with ageing so no source starves. Grants drive one registered write stage
//  that feeds the regfile directly. Writes to x0 are consumed without occupying the port.
// PARAMETERS
//  N_REQ      3   number of writeback requesters (2..8)
//  STARVE_MAX 4   wait cycles after which a requester is promoted above all non-starved ones
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  req_valid  in   N_REQ       requester i holds a write
//  req_rd     in   N_REQ x 5   destination register per requester
//  req_data   in   N_REQ x 32  write data per requester
//  req_ready  out  N_REQ       combinational accept; transfer = valid & ready
//  rf_we      out  1           regfile write enable (registered)
//  rf_a3      out  5           regfile write address (registered)
//  rf_din     out  32          regfile write data (registered)
//  grant_id   out  3           index of last granted requester (registered, debug)
//  byp_a1/2   in   5           [WB_BYPASS_EN] read addresses presented to the regfile
//  rf_rd1/2   in   32          [WB_BYPASS_EN] raw regfile read data
//  fwd_rd1/2  out  32          [WB_BYPASS_EN] forwarded read data
// BEHAVIOUR
//  - Reset (async): rf_we=0, rf_a3=0, rf_din=0, grant_id=0, all age counters=0. req_ready=0 while rst is high.
//  - Handshake: valid stays high with stable rd/data until ready. Ready never depends on the same requester's data.
//  - x0 requests (valid & rd==0): ready=1 in the same cycle regardless of arbitration. No write issued, age cleared.
//  - Arbitration, once per cycle, among valid requests with rd!=0:
//    - starved (age>=STARVE_MAX) requesters first, lowest index wins;
//    - otherwise lowest index wins.
//    - Exactly one ready per cycle among rd!=0 requests.
//  - Latency: a grant in cycle T gives rf_we=1 with winner's rd/data during T+1.
//    The regfile commits at the edge ending T+1. Back-to-back grants give full throughput.
//  - No grant in cycle T: rf_we=0 in T+1. rf_a3/rf_din hold their old values.
//  - Age counter i: +1 per cycle with valid & !ready, saturating at STARVE_MAX. Cleared on transfer or when valid=0.
//  - Same rd from two requesters in one cycle: the winner writes first, the loser writes on a later grant
//    (last grant wins). No merging.
//  - Reset mid-transfer: the pending registered write is dropped (rf_we=0 immediately). Requesters must re-present.
// CONFIGURATION
//  - WB_BYPASS_EN defined:
//    - fwd_rdN = rf_din when rf_we & byp_aN==rf_a3 & rf_a3!=0, else rf_rdN.
//    - This closes the write-then-read gap of the registered stage.
//  - Undefined: bypass ports absent; consumers read the regfile directly and the hazard unit stalls 1 cycle.
// STRUCTURE
//  - Package wb_arb_pkg: XLEN=32, REG_AW=5, GID_W=3;
//    typedef struct packed {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;} wb_req_t.
//  - Sub-module wb_age_counter (one per requester): saturating counter with clear, starved flag out.
//  - Top level: arbitration logic plus the output register stage.
// TESTING
//  1. Reset: assert rst mid-cycle with rf_we=1 -> rf_we=0 and rf_a3=0 at once; req_ready=0 until release.
//  2. Priority: valid 0,1,2 together (rd=5,6,7, data 0xA,0xB,0xC), held on each new grant -> writes x5, x6, x7
//     on consecutive cycles; readies one-hot 001, 010, 100.
//  3. Starvation: req0 valid every cycle with new rd; req2 rd=9 data=0xDEAD held -> req2 granted after exactly
//     STARVE_MAX=4 waiting cycles; rf_a3=9 next cycle.
//  4. x0 drop: req1 rd=0 and req0 rd=3 both valid -> both ready in the same cycle; only x3 written; rf_we pulses once.
//  5. Idle/hold: no valid for 3 cycles after a write of x4=0x55 -> rf_we=0; rf_a3=4 and rf_din=0x55 held.
//  6. [WB_BYPASS_EN] rf_we=1 for x8=0x1234, byp_a1=8, rf_rd1=0 -> fwd_rd1=0x1234.
//     With rf_a3=0 -> passes rf_rd1.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared widths and request payload type for the writeback arbiter
package wb_arb_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int GID_W  = 3;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - requester/regfile bundle; bypass signals exist only with WB_BYPASS_EN
interface wb_port_arbiter_if
   import wb_arb_pkg::*;
#(
   parameter int N_REQ = 3
) ();
   logic [N_REQ-1:0]             req_valid;
   logic [N_REQ-1:0][REG_AW-1:0] req_rd;
   logic [N_REQ-1:0][XLEN-1:0]   req_data;
   logic [N_REQ-1:0]             req_ready;
   logic                         rf_we;
   logic [REG_AW-1:0]            rf_a3;
   logic [XLEN-1:0]              rf_din;
   logic [GID_W-1:0]             grant_id;
`ifdef WB_BYPASS_EN
   logic [REG_AW-1:0]            byp_a1;
   logic [REG_AW-1:0]            byp_a2;
   logic [XLEN-1:0]              rf_rd1;
   logic [XLEN-1:0]              rf_rd2;
   logic [XLEN-1:0]              fwd_rd1;
   logic [XLEN-1:0]              fwd_rd2;

   modport master (
      output req_valid, req_rd, req_data, byp_a1, byp_a2, rf_rd1, rf_rd2,
      input  req_ready, rf_we, rf_a3, rf_din, grant_id, fwd_rd1, fwd_rd2
   );
   modport slave (
      input  req_valid, req_rd, req_data, byp_a1, byp_a2, rf_rd1, rf_rd2,
      output req_ready, rf_we, rf_a3, rf_din, grant_id, fwd_rd1, fwd_rd2
   );
`else
   modport master (
      output req_valid, req_rd, req_data,
      input  req_ready, rf_we, rf_a3, rf_din, grant_id
   );
   modport slave (
      input  req_valid, req_rd, req_data,
      output req_ready, rf_we, rf_a3, rf_din, grant_id
   );
`endif
endinterface

// File: rtl/wb_port_arbiter_age_counter.sv
// rtl/wb_port_arbiter_age_counter.sv - per-requester wait counter, saturating, flags starvation
module wb_age_counter #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_valid,
   input  logic i_ready,
   output logic o_starved
);
   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] r_age;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_age <= '0;
      end else if (!i_valid || i_ready) begin
         r_age <= '0;
      end else if (r_age < CW'(STARVE_MAX)) begin
         r_age <= r_age + CW'(1);
      end
   end

   assign o_starved = (r_age >= CW'(STARVE_MAX));
endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - ageing fixed-priority arbiter onto one registered regfile write port; WB_BYPASS_EN adds read forwarding
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int N_REQ      = 3,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   wb_port_arbiter_if.slave  io_wb
);
   wb_req_t          w_req [N_REQ];
   logic [N_REQ-1:0] w_x0;
   logic [N_REQ-1:0] w_cand;
   logic [N_REQ-1:0] w_starved;
   logic [N_REQ-1:0] w_pool;
   logic [N_REQ-1:0] w_grant;
   logic [N_REQ-1:0] w_ready;
   logic [GID_W-1:0] w_gid;
   wb_req_t          w_win;
   logic             w_any;

   logic             r_we;
   logic [REG_AW-1:0] r_a3;
   logic [XLEN-1:0]  r_din;
   logic [GID_W-1:0] r_gid;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         w_req[i].rd   = io_wb.req_rd[i];
         w_req[i].data = io_wb.req_data[i];
         w_x0[i]       = io_wb.req_valid[i] && (w_req[i].rd == '0);
         w_cand[i]     = io_wb.req_valid[i] && (w_req[i].rd != '0);
      end
   end

   // Starved candidates form the pool whenever any exist; lowest index wins inside the pool.
   assign w_pool = |(w_cand & w_starved) ? (w_cand & w_starved) : w_cand;
   assign w_any  = |w_pool;

   always_comb begin
      w_grant = '0;
      w_gid   = '0;
      w_win   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_pool[i]) begin
            w_grant    = '0;
            w_grant[i] = 1'b1;
            w_gid      = GID_W'(i);
            w_win      = w_req[i];
         end
      end
   end

   // x0 writes are swallowed here, so they never consume the write port.
   assign w_ready         = rst ? '0 : (w_x0 | w_grant);
   assign io_wb.req_ready = w_ready;

   for (genvar g = 0; g < N_REQ; g++) begin : g_age
      wb_age_counter #(.STARVE_MAX(STARVE_MAX)) u_age (
         .clk       (clk),
         .rst       (rst),
         .i_valid   (io_wb.req_valid[g]),
         .i_ready   (w_ready[g]),
         .o_starved (w_starved[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we  <= 1'b0;
         r_a3  <= '0;
         r_din <= '0;
         r_gid <= '0;
      end else begin
         r_we <= w_any;
         if (w_any) begin
            r_a3  <= w_win.rd;
            r_din <= w_win.data;
            r_gid <= w_gid;
         end
      end
   end

   assign io_wb.rf_we    = r_we;
   assign io_wb.rf_a3    = r_a3;
   assign io_wb.rf_din   = r_din;
   assign io_wb.grant_id = r_gid;

`ifdef WB_BYPASS_EN
   assign io_wb.fwd_rd1 = (r_we && io_wb.byp_a1 == r_a3 && r_a3 != '0) ? r_din : io_wb.rf_rd1;
   assign io_wb.fwd_rd2 = (r_we && io_wb.byp_a2 == r_a3 && r_a3 != '0) ? r_din : io_wb.rf_rd2;
`endif
endmodule
